// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: request/response sequencer between the SLC-3 control unit
// (MAR/MDR side) and a synchronous BRAM with RD_LAT cycles of read latency.
// Each accepted request yields exactly one single-cycle rsp_valid pulse.
// Optional build macro SLC3_MMIO_SWITCH_EN: accesses to IO_ADDR bypass the
// BRAM. Reads return sw_in and writes load the hex_out register.
module mem_access_ctrl #(
    parameter int unsigned         ADDR_W  = 16,
    parameter int unsigned         DATA_W  = 16,
    parameter int unsigned         RD_LAT  = 2,
    parameter logic [ADDR_W-1:0]   IO_ADDR = 16'hFFFF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    input  logic [DATA_W-1:0] sw_in,
    output logic [DATA_W-1:0] hex_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Remaining wait cycles after the enable cycle before bram_dout is valid
    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              accept;
    logic              io_hit;

    assign accept = (state_q == S_IDLE) && req_valid;

`ifdef SLC3_MMIO_SWITCH_EN
    logic [DATA_W-1:0] hex_q, hex_d;

    assign io_hit  = (addr_q == IO_ADDR);
    assign hex_out = hex_q;
`else
    // sw_in and IO_ADDR have no consumer when the I/O decode is not built
    logic unused_io;

    assign io_hit    = 1'b0;
    assign hex_out   = '0;
    assign unused_io = ^{sw_in, IO_ADDR};
`endif

    // Capture the request fields on acceptance; only the IDLE state accepts
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            wdata_q <= req_wdata;
        end
    end

    // Next-state, latency counter and read-data capture decisions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
`ifdef SLC3_MMIO_SWITCH_EN
        hex_d   = hex_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef SLC3_MMIO_SWITCH_EN
                if (io_hit) begin
                    state_d = S_RESP;
                    if (we_q) begin
                        hex_d = wdata_q;
                    end else begin
                        rdata_d = sw_in;
                    end
                end else
`endif
                if (we_q) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = bram_dout;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state, counter and held read data
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef SLC3_MMIO_SWITCH_EN
    // Hex display register, written only by accesses to IO_ADDR
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hex_q <= '0;
        end else begin
            hex_q <= hex_d;
        end
    end
`endif

    // The capture registers drive the BRAM address/data directly, so both
    // hold their last value outside ISSUE without extra output registers.
    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign bram_en   = (state_q == S_ISSUE) && !io_hit;
    assign bram_we   = bram_en && we_q;
    assign bram_addr = addr_q;
    assign bram_din  = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: scoreboard of expected responses fed by the
// stimulus process, checked by an independent negedge monitor.
module tb_mem_access_ctrl;

    localparam int unsigned RD_LAT = 2;
    localparam logic [15:0] IO_A   = 16'hFFFF;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [15:0] sw_in = 16'h00A5;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        bram_en;
    logic        bram_we;
    logic [15:0] bram_addr;
    logic [15:0] bram_din;
    logic [15:0] bram_dout;
    logic [15:0] hex_out;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned next_ready = 0;

    typedef struct {
        bit          we;
        bit          io;
        logic [15:0] addr;
        logic [15:0] data;
        int unsigned acc;
        int unsigned lat;
    } txn_t;

    txn_t        sb[$];
    txn_t        mon_t;
    bit          mon_en;
    logic [15:0] exp_last = '0;
    logic [15:0] hex_exp = '0;

    // Reference model memory (written by the stimulus side only)
    bit          ref_wr  [0:65535];
    logic [15:0] ref_val [0:65535];

    // Environment BRAM: enable cycle, internal stage, output register
    bit          bram_wr  [0:65535];
    logic [15:0] bram_mem [0:65535];
    logic [15:0] stage = '0;
    logic [15:0] dout_r = '0;

    mem_access_ctrl #(
        .ADDR_W (16),
        .DATA_W (16),
        .RD_LAT (RD_LAT),
        .IO_ADDR(IO_A)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .req_valid(req_valid),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .bram_en  (bram_en),
        .bram_we  (bram_we),
        .bram_addr(bram_addr),
        .bram_din (bram_din),
        .bram_dout(bram_dout),
        .sw_in    (sw_in),
        .hex_out  (hex_out)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0010) return 16'h1234;
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic bit is_io(input logic [15:0] a);
`ifdef SLC3_MMIO_SWITCH_EN
        return (a == IO_A);
`else
        return (a == 16'h0000) && (a != 16'h0000);
`endif
    endfunction

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return IO_A;
        return 16'(16'h0010 + $urandom_range(0, 15));
    endfunction

    always @(posedge Clk) begin
        if (bram_en) begin
            if (bram_we) begin
                bram_mem[bram_addr] <= bram_din;
                bram_wr[bram_addr]  <= 1'b1;
            end else begin
                stage <= bram_wr[bram_addr] ? bram_mem[bram_addr] : init_val(bram_addr);
            end
        end
        dout_r <= stage;
    end
    assign bram_dout = dout_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus, driven at a negedge; returns at the next negedge
    task automatic drive(input bit v, input bit we, input logic [15:0] a, input logic [15:0] d);
        txn_t t;
        bit   acc_now;
        acc_now   = 1'b0;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        if (v && cyc >= next_ready) begin
            acc_now = 1'b1;
            t.we   = we;
            t.io   = is_io(a);
            t.addr = a;
            t.acc  = cyc;
            if (we) begin
                t.data = d;
                t.lat  = 2;
                if (t.io) begin
                    hex_exp = d;
                end else begin
                    ref_wr[a]  = 1'b1;
                    ref_val[a] = d;
                end
            end else begin
                t.data = t.io ? sw_in : (ref_wr[a] ? ref_val[a] : init_val(a));
                t.lat  = t.io ? 2 : 2 + RD_LAT;
            end
            next_ready = cyc + t.lat + 1;
        end
        @(posedge Clk);
        if (acc_now) sb.push_back(t);
        @(negedge Clk);
    endtask

    task automatic do_op(input bit we, input logic [15:0] a, input logic [15:0] d);
        while (cyc < next_ready) drive(1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, we, a, d);
        req_valid = 1'b0;
    endtask

    // Monitor: per-cycle handshake/BRAM checks and response scoreboard
    always @(negedge Clk) begin
        if (!Reset) begin
            chk("req_ready", req_ready, sb.size() == 0);
            mon_en = (sb.size() > 0) && (cyc == sb[0].acc + 1) && !sb[0].io;
            chk("bram_en", bram_en, mon_en);
            chk("bram_we", bram_we, mon_en && sb[0].we);
            if (mon_en) begin
                chk("bram_addr", bram_addr, sb[0].addr);
                if (sb[0].we) chk("bram_din", bram_din, sb[0].data);
            end
            if (rsp_valid || (sb.size() > 0 && cyc == sb[0].acc + sb[0].lat)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_spurious: got rsp_valid=1 expected no response (cycle %0d)", cyc);
                end else begin
                    mon_t = sb.pop_front();
                    chk("rsp_latency", cyc - mon_t.acc, mon_t.lat);
                    chk("rsp_valid", rsp_valid, 1);
                    if (!mon_t.we) exp_last = mon_t.data;
                    chk("rsp_rdata", rsp_rdata, exp_last);
                    chk("hex_out", hex_out, hex_exp);
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_bram_en"},   bram_en, 0);
        chk({tag, "_bram_we"},   bram_we, 0);
        chk({tag, "_bram_addr"}, bram_addr, 0);
        chk({tag, "_bram_din"},  bram_din, 0);
        chk({tag, "_hex_out"},   hex_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge Clk);
        chk_reset_outputs("reset");
        Reset      = 1'b0;
        next_ready = cyc;

        // Preloaded read, write then read-back, I/O address
        do_op(1'b0, 16'h0010, 16'h0000);
        do_op(1'b1, 16'h0020, 16'hBEEF);
        do_op(1'b0, 16'h0020, 16'h0000);
        do_op(1'b1, IO_A, 16'h0042);
        do_op(1'b0, IO_A, 16'h0000);

        // req_valid held high with changing fields every cycle
        for (int i = 0; i < 150; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
        end

        // Asynchronous reset while a read sits in WAIT
        do_op(1'b0, 16'h0017, 16'h0000);
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        #1 Reset = 1'b1;
        #1 chk_reset_outputs("midreset");
        sb.delete();
        exp_last = '0;
        hex_exp  = '0;
        @(negedge Clk);
        @(negedge Clk);
        Reset      = 1'b0;
        next_ready = cyc;
        do_op(1'b0, 16'h0017, 16'h0000);

        // Random traffic with idle gaps
        for (int i = 0; i < 150; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
        end

        req_valid = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) drive(1'b0, 1'b0, 16'h0, 16'h0);
        chk("drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
